mem_channel_model: RTL and testbench
====================================

// Module: mem_channel_model
// PURPOSE
//  Synthesizable multi-channel memory model for the GPU data and program memory ports.
//  Replaces the behavioural testbench memory class so kernels run in simulation, FPGA
//  and emulation without calling run() each cycle.
//  Each channel has its own four-phase valid/ready read and write handshake with
//  parametrised latency. A backdoor load port preloads the array before start.
// PARAMETERS
//  ADDR_BITS   8    address width per channel
//  DATA_BITS   8    word width (16 for program memory)
//  CHANNELS    4    number of independent request channels
//  DEPTH       256  implemented words, 1..2**ADDR_BITS; higher addresses are out of range
//  LATENCY     2    cycles from request acceptance to ready, >=1
// PORTS
//  clk                 in   1                     clock, rising edge
//  reset               in   1                     async, active-low (0 = reset)
//  mem_read_valid      in   CHANNELS              per-channel read request
//  mem_read_address    in   CHANNELS*ADDR_BITS    read address, channel c at [c*ADDR_BITS +: ADDR_BITS]
//  mem_read_ready      out  CHANNELS              read data valid / request done
//  mem_read_data       out  CHANNELS*DATA_BITS    read data, channel c at [c*DATA_BITS +: DATA_BITS]
//  mem_write_valid     in   CHANNELS              per-channel write request
//  mem_write_address   in   CHANNELS*ADDR_BITS    write address
//  mem_write_data      in   CHANNELS*DATA_BITS    write data
//  mem_write_ready     out  CHANNELS              write done
//  load_en             in   1                     backdoor write strobe
//  load_addr           in   ADDR_BITS             backdoor address
//  load_data           in   DATA_BITS             backdoor data
//  oob_error           out  1                     sticky: an out-of-range access occurred
// BEHAVIOUR
//  Reset (reset==0, async)
//  - All channel FSMs go to IDLE.
//  - mem_read_ready, mem_write_ready, mem_read_data and oob_error all go to 0.
//  - Array contents are NOT cleared. A reset mid-transaction aborts it; a pending write is discarded.
//  Per-channel FSM
//  - IDLE: on a rising edge with write_valid=1, latch addr/data and go to WBUSY.
//    Otherwise, with read_valid=1, latch addr and go to RBUSY.
//    Write wins when both are valid; the read stays pending and is accepted after the write completes.
//  - RBUSY/WBUSY: count LATENCY-1 further edges.
//    On the final edge: commit the write to the array, or register the read data.
//    Then go to RESP and assert the matching ready.
//  - RESP: ready stays 1 and read_data stays stable while the requester's valid is 1.
//    On the first edge with that valid=0, drop ready and return to IDLE.
//    A new request can be accepted no earlier than the following edge.
//  - Timing: request sampled at edge N -> ready visible after edge N+LATENCY.
//    Minimum round trip is LATENCY+2 cycles.
//  Array semantics
//  - Read data is the array value at the RBUSY->RESP edge.
//    A write committing on that same edge is not visible: the old value is returned.
//  - Same-address writes committing on the same edge: the lowest channel index wins.
//    load_en overrides every channel write to the same address.
//  - Any address >= DEPTH is out of range.
//    An out-of-range read returns 0; an out-of-range write is dropped.
//    Both complete the handshake normally and set oob_error until reset.
//  - A load_en with an out-of-range address is ignored and does not set oob_error.
//  - Address arithmetic is unsigned with no wrap-around; ADDR_BITS bits are used as-is.
//  - Channels are fully independent; there is no arbitration delay between them.
// TESTING
//  1. Preload words 0..7 = 1,2,3,4,1,2,3,4; ch0 reads addr 3 at cycle 10
//     -> ready rises after edge 12, data=4, held until valid drops.
//  2. All 4 channels write addr 9 (data 10,11,12,13) on the same edge -> later read of 9 = 10.
//  3. ch1 read_valid and write_valid together, addr 5, wdata 0x55
//     -> write_ready first; after the handshake the read returns 0x55.
//  4. DEPTH=16, ch2 reads addr 20 -> data 0, ready asserted, oob_error=1 until reset.
//  5. Drive reset=0 mid-RBUSY on ch0 -> ready 0 immediately (async), FSM IDLE, array unchanged.
//  6. Run the 2x2 matmul kernel on the gpu with LATENCY=1 and LATENCY=4
//     -> words 8..11 = 7,10,15,22 in both runs.

Source files
------------

// File: rtl/mem_channel_model_if.sv
// Request/response bundle for mem_channel_model: per-channel read and write
// valid/ready handshakes, with each channel's field packed into flat vectors.
interface mem_channel_model_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4
);
  logic [CHANNELS-1:0]           mem_read_valid;
  logic [CHANNELS*ADDR_BITS-1:0] mem_read_address;
  logic [CHANNELS-1:0]           mem_read_ready;
  logic [CHANNELS*DATA_BITS-1:0] mem_read_data;
  logic [CHANNELS-1:0]           mem_write_valid;
  logic [CHANNELS*ADDR_BITS-1:0] mem_write_address;
  logic [CHANNELS*DATA_BITS-1:0] mem_write_data;
  logic [CHANNELS-1:0]           mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/mem_channel_model.sv
// Multi-channel memory model: independent per-channel read/write FSMs with
// fixed latency over one shared array, plus a backdoor load port.
module mem_channel_model #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_channel_model_if.slave   bus,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [DATA_BITS-1:0] load_data,
  output logic                 oob_error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RBUSY,
    WBUSY,
    RESP_R,
    RESP_W
  } state_t;

  state_t               state_q [CHANNELS];
  state_t               state_d [CHANNELS];
  logic [CW-1:0]        cnt_q   [CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [CHANNELS];
  logic [DATA_BITS-1:0] wdata_q [CHANNELS];
  logic [DATA_BITS-1:0] rdata_q [CHANNELS];

  logic [ADDR_BITS-1:0] rd_addr [CHANNELS];
  logic [ADDR_BITS-1:0] wr_addr [CHANNELS];
  logic [DATA_BITS-1:0] wr_data [CHANNELS];

  logic [CHANNELS-1:0] accept_wr;
  logic [CHANNELS-1:0] accept_rd;
  logic [CHANNELS-1:0] done;

  logic [CHANNELS-1:0]           rd_ready;
  logic [CHANNELS-1:0]           wr_ready;
  logic [CHANNELS*DATA_BITS-1:0] rd_data_flat;

  logic [DATA_BITS-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return {1'b0, a} < (ADDR_BITS + 1)'(DEPTH);
  endfunction

  function automatic logic [IW-1:0] idx(input logic [ADDR_BITS-1:0] a);
    return IW'(a);
  endfunction

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rd_addr[c] = bus.mem_read_address[c*ADDR_BITS +: ADDR_BITS];
      wr_addr[c] = bus.mem_write_address[c*ADDR_BITS +: ADDR_BITS];
      wr_data[c] = bus.mem_write_data[c*DATA_BITS +: DATA_BITS];
    end
  end

  // A write wins over a simultaneous read; the read valid stays high and is
  // picked up once the write handshake has fully closed.
  always_comb begin
    accept_wr = '0;
    accept_rd = '0;
    done      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      unique case (state_q[c])
        IDLE: begin
          if (bus.mem_write_valid[c]) begin
            state_d[c]   = WBUSY;
            accept_wr[c] = 1'b1;
          end else if (bus.mem_read_valid[c]) begin
            state_d[c]   = RBUSY;
            accept_rd[c] = 1'b1;
          end
        end
        RBUSY: begin
          if (cnt_q[c] == CNT_LAST) begin
            state_d[c] = RESP_R;
            done[c]    = 1'b1;
          end
        end
        WBUSY: begin
          if (cnt_q[c] == CNT_LAST) begin
            state_d[c] = RESP_W;
            done[c]    = 1'b1;
          end
        end
        RESP_R: if (!bus.mem_read_valid[c])  state_d[c] = IDLE;
        RESP_W: if (!bus.mem_write_valid[c]) state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
        rdata_q[c] <= '0;
      end
      oob_error <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        if ((state_q[c] == RBUSY || state_q[c] == WBUSY) && !done[c]) begin
          cnt_q[c] <= cnt_q[c] + CW'(1);
        end else begin
          cnt_q[c] <= '0;
        end
        if (accept_wr[c]) begin
          addr_q[c]  <= wr_addr[c];
          wdata_q[c] <= wr_data[c];
        end else if (accept_rd[c]) begin
          addr_q[c] <= rd_addr[c];
        end
        // Sampling here returns the pre-write value if a write commits this edge.
        if (done[c] && state_q[c] == RBUSY) begin
          rdata_q[c] <= in_range(addr_q[c]) ? mem[idx(addr_q[c])] : '0;
        end
        if (done[c] && !in_range(addr_q[c])) begin
          oob_error <= 1'b1;
        end
      end
    end
  end

  // Later assignments win: walking channels downward gives the lowest index
  // priority, and the backdoor load overrides them all.
  always_ff @(posedge clk) begin
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (done[c] && state_q[c] == WBUSY && in_range(addr_q[c])) begin
        mem[idx(addr_q[c])] <= wdata_q[c];
      end
    end
    if (load_en && in_range(load_addr)) begin
      mem[idx(load_addr)] <= load_data;
    end
  end

  always_comb begin
    rd_ready     = '0;
    wr_ready     = '0;
    rd_data_flat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rd_ready[c] = (state_q[c] == RESP_R);
      wr_ready[c] = (state_q[c] == RESP_W);
      rd_data_flat[c*DATA_BITS +: DATA_BITS] = rdata_q[c];
    end
  end

  assign bus.mem_read_ready  = rd_ready;
  assign bus.mem_write_ready = wr_ready;
  assign bus.mem_read_data   = rd_data_flat;

endmodule

// File: tb/tb_mem_channel_model.sv
// Directed self-checking bench for mem_channel_model (DEPTH=16, LATENCY=2),
// one task per scenario with hand-computed expectations.
module tb_mem_channel_model;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NCH = 4;

  logic          clk;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          oob_error;

  int vectors;
  int miscompares;

  mem_channel_model_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .CHANNELS(NCH)) bus ();

  mem_channel_model #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .CHANNELS(NCH), .DEPTH(16), .LATENCY(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .oob_error (oob_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rdata(input int ch);
    return bus.mem_read_data[ch*DW +: DW];
  endfunction

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic start_read(input int ch, input logic [AW-1:0] a);
    bus.mem_read_address[ch*AW +: AW] = a;
    bus.mem_read_valid[ch] = 1'b1;
  endtask

  task automatic start_write(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mem_write_address[ch*AW +: AW] = a;
    bus.mem_write_data[ch*DW +: DW]    = d;
    bus.mem_write_valid[ch] = 1'b1;
  endtask

  // lat = edges after the accepting edge until ready is seen (20 = timed out)
  task automatic wait_rd(input int ch, output int lat);
    tick();
    lat = 0;
    while (bus.mem_read_ready[ch] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_wr(input int ch, output int lat);
    tick();
    lat = 0;
    while (bus.mem_write_ready[ch] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_rd(input int ch);
    bus.mem_read_valid[ch] = 1'b0;
    tick();
  endtask

  task automatic release_wr(input int ch);
    bus.mem_write_valid[ch] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    bus.mem_read_valid    = '0;
    bus.mem_read_address  = '0;
    bus.mem_write_valid   = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    tick();
    tick();
    vectors++;
    if (bus.mem_read_ready !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rd_ready: got %h expected 0", bus.mem_read_ready);
    end
    vectors++;
    if (bus.mem_write_ready !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_wr_ready: got %h expected 0", bus.mem_write_ready);
    end
    vectors++;
    if (bus.mem_read_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rd_data: got %h expected 0", bus.mem_read_data);
    end
    vectors++;
    if (oob_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_oob: got %b expected 0", oob_error);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read_latency();
    int lat;
    for (int i = 0; i < 8; i++) load_word(AW'(i), DW'((i % 4) + 1));
    start_read(0, 8'd3);
    wait_rd(0, lat);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL rd_latency: got %0d expected 2", lat);
    end
    vectors++;
    if (rdata(0) !== 8'd4) begin
      miscompares++;
      $display("[TB] FAIL rd_data_addr3: got %h expected 04", rdata(0));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.mem_read_ready[0] !== 1'b1 || rdata(0) !== 8'd4) begin
        miscompares++;
        $display("[TB] FAIL rd_hold: got ready=%b data=%h expected ready=1 data=04",
                 bus.mem_read_ready[0], rdata(0));
      end
    end
    release_rd(0);
    vectors++;
    if (bus.mem_read_ready[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rd_release: got ready=%b expected 0", bus.mem_read_ready[0]);
    end
    start_read(3, 8'd6);
    wait_rd(3, lat);
    vectors++;
    if (rdata(3) !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL rd_ch3_addr6: got %h expected 03", rdata(3));
    end
    release_rd(3);
  endtask

  task automatic test_same_addr_write();
    int lat;
    for (int c = 0; c < NCH; c++) start_write(c, 8'd9, DW'(10 + c));
    tick();
    lat = 0;
    while (bus.mem_write_ready !== 4'hF && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL wr_all_latency: got %0d expected 2", lat);
    end
    bus.mem_write_valid = '0;
    tick();
    vectors++;
    if (bus.mem_write_ready !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL wr_all_release: got %h expected 0", bus.mem_write_ready);
    end
    start_read(2, 8'd9);
    wait_rd(2, lat);
    vectors++;
    if (rdata(2) !== 8'd10) begin
      miscompares++;
      $display("[TB] FAIL wr_lowest_wins: got %h expected 0a", rdata(2));
    end
    release_rd(2);
  endtask

  task automatic test_write_wins();
    int lat;
    start_write(1, 8'd5, 8'h55);
    start_read(1, 8'd5);
    wait_wr(1, lat);
    vectors++;
    if (lat !== 2 || bus.mem_read_ready[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wr_first: got lat=%0d rd_ready=%b expected lat=2 rd_ready=0",
               lat, bus.mem_read_ready[1]);
    end
    release_wr(1);
    lat = 0;
    while (bus.mem_read_ready[1] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("[TB] FAIL pending_rd_latency: got %0d expected 3", lat);
    end
    vectors++;
    if (rdata(1) !== 8'h55) begin
      miscompares++;
      $display("[TB] FAIL pending_rd_data: got %h expected 55", rdata(1));
    end
    release_rd(1);
  endtask

  task automatic test_same_edge_rw();
    int lat;
    start_read(0, 8'd4);
    start_write(1, 8'd4, 8'h44);
    tick();
    tick();
    tick();
    vectors++;
    if (bus.mem_read_ready[0] !== 1'b1 || bus.mem_write_ready[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL same_edge_ready: got rd=%b wr=%b expected 1 1",
               bus.mem_read_ready[0], bus.mem_write_ready[1]);
    end
    vectors++;
    if (rdata(0) !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL same_edge_old_value: got %h expected 01", rdata(0));
    end
    bus.mem_write_valid[1] = 1'b0;
    release_rd(0);
    start_read(0, 8'd4);
    wait_rd(0, lat);
    vectors++;
    if (lat !== 2 || rdata(0) !== 8'h44) begin
      miscompares++;
      $display("[TB] FAIL b2b_read: got lat=%0d data=%h expected lat=2 data=44", lat, rdata(0));
    end
    release_rd(0);
  endtask

  task automatic test_load_override();
    int lat;
    start_write(0, 8'd7, 8'h70);
    tick();
    tick();
    load_en   = 1'b1;
    load_addr = 8'd7;
    load_data = 8'h77;
    tick();
    load_en   = 1'b0;
    vectors++;
    if (bus.mem_write_ready[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL load_ovr_ready: got %b expected 1", bus.mem_write_ready[0]);
    end
    release_wr(0);
    start_read(0, 8'd7);
    wait_rd(0, lat);
    vectors++;
    if (rdata(0) !== 8'h77) begin
      miscompares++;
      $display("[TB] FAIL load_ovr_data: got %h expected 77", rdata(0));
    end
    release_rd(0);
  endtask

  task automatic test_oob();
    int lat;
    load_word(8'd25, 8'h99);
    vectors++;
    if (oob_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oob_load_ignored: got %b expected 0", oob_error);
    end
    start_read(2, 8'd20);
    wait_rd(2, lat);
    vectors++;
    if (lat !== 2 || rdata(2) !== 8'h00 || oob_error !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL oob_read: got lat=%0d data=%h oob=%b expected lat=2 data=00 oob=1",
               lat, rdata(2), oob_error);
    end
    release_rd(2);
    load_word(8'd14, 8'hEE);
    start_write(3, 8'd30, 8'h11);
    wait_wr(3, lat);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL oob_write_handshake: got lat=%0d expected 2", lat);
    end
    release_wr(3);
    start_read(0, 8'd14);
    wait_rd(0, lat);
    vectors++;
    if (rdata(0) !== 8'hEE) begin
      miscompares++;
      $display("[TB] FAIL oob_write_dropped: got %h expected ee", rdata(0));
    end
    release_rd(0);
    start_read(1, 8'd9);
    wait_rd(1, lat);
    vectors++;
    if (rdata(1) !== 8'd10 || oob_error !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL oob_load_alias: got data=%h oob=%b expected data=0a oob=1",
               rdata(1), oob_error);
    end
    release_rd(1);
  endtask

  task automatic test_reset_mid();
    int lat;
    start_read(0, 8'd3);
    wait_rd(0, lat);
    start_write(1, 8'd2, 8'hAA);
    tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.mem_read_ready !== 4'h0 || bus.mem_read_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_rd: got ready=%h data=%h expected 0 0",
               bus.mem_read_ready, bus.mem_read_data);
    end
    vectors++;
    if (oob_error !== 1'b0 || bus.mem_write_ready !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_oob: got oob=%b wr_ready=%h expected 0 0",
               oob_error, bus.mem_write_ready);
    end
    bus.mem_read_valid  = '0;
    bus.mem_write_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    start_read(0, 8'd2);
    wait_rd(0, lat);
    vectors++;
    if (lat !== 2 || rdata(0) !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL reset_discards_write: got lat=%0d data=%h expected lat=2 data=03",
               lat, rdata(0));
    end
    release_rd(0);
    start_read(0, 8'd3);
    wait_rd(0, lat);
    vectors++;
    if (rdata(0) !== 8'd4) begin
      miscompares++;
      $display("[TB] FAIL reset_keeps_array: got %h expected 04", rdata(0));
    end
    release_rd(0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_read_latency();
    test_same_addr_write();
    test_write_wins();
    test_same_edge_rw();
    test_load_override();
    test_oob();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
